// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline sequencing unit: the FSM state encoding,
// the architectural register aliases and the bubble instruction encoding.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [3:0]  REG_SP   = 4'd13;
    localparam logic [3:0]  REG_LR   = 4'd14;
    // Instruction word loaded by a flush: decodes with RegWrite=0.
    localparam logic [15:0] NOP_INSN = 16'h0000;

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle of the hazard unit's pipeline-facing signals.
//  master: the pipeline side (drives ID/EX/MEM status, receives enables/flushes)
//  slave : the hazard controller
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       id_rs1;
    logic [3:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_halt;
    logic [3:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ack;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
               ex_rd, ex_mem_read, ex_reg_write, ex_branch_taken, mem_req, mem_ack,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, halted, mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
               ex_rd, ex_mem_read, ex_reg_write, ex_branch_taken, mem_req, mem_ack,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, halted, mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
//  clk, reset (sync, active-low), inc, clr (wins over inc), q
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset)                      cnt_q <= '0;
        else if (clr)                    cnt_q <= '0;
        else if (inc && (cnt_q != '1))   cnt_q <= cnt_q + 1'b1;
    end

    assign q = cnt_q;
endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing unit for the 16-bit 5-stage core: stage enables and
// bubble flushes for memory wait states, taken branches, load-use stalls and
// halt drain, plus stall/flush event counters and a sticky memory timeout.
//  clk, reset : core clock, synchronous active-low reset
//  bus        : hazard_controller_if slave (ID/EX/MEM status in, controls out)
module hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    hazard_controller_if.slave  bus
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            timeout_q;
    logic [WW-1:0]   wait_q;
    logic            stall_inc, flush_inc;

    // A zero-wait access (req & ack together) does not freeze.
    logic freeze;
    assign freeze = bus.mem_req & ~bus.mem_ack;

    logic load_use;
    assign load_use = bus.ex_mem_read & bus.ex_reg_write &
                      ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

    always_comb begin
        bus.pc_en       = 1'b1;
        bus.if_id_en    = 1'b1;
        bus.id_ex_en    = 1'b1;
        bus.ex_mem_en   = 1'b1;
        bus.mem_wb_en   = 1'b1;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        state_d         = state_q;
        drain_d         = drain_q;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;

        if (!reset) begin
            // pipeline registers clear themselves; keep defaults
        end else if (freeze || state_q == ST_HALTED) begin
            bus.pc_en     = 1'b0;
            bus.if_id_en  = 1'b0;
            bus.id_ex_en  = 1'b0;
            bus.ex_mem_en = 1'b0;
            bus.mem_wb_en = 1'b0;
        end else if (bus.ex_branch_taken) begin
            // A halt being drained was on the wrong path: cancel it.
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            flush_inc       = 1'b1;
            state_d         = ST_RUN;
        end else if (state_q == ST_RUN && load_use) begin
            bus.pc_en       = 1'b0;
            bus.if_id_en    = 1'b0;
            bus.id_ex_flush = 1'b1;
            stall_inc       = 1'b1;
        end else if (state_q == ST_RUN && bus.id_halt) begin
            bus.pc_en       = 1'b0;
            bus.if_id_en    = 1'b0;
            bus.id_ex_flush = 1'b1;
            drain_d         = DW'(DRAIN_CYCLES - 1);
            state_d         = ST_DRAIN;
        end else if (state_q == ST_DRAIN) begin
            bus.pc_en       = 1'b0;
            bus.if_id_en    = 1'b0;
            bus.id_ex_flush = 1'b1;
            if (drain_q == '0) state_d = ST_HALTED;
            else               drain_d = drain_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            drain_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            // wait_q counts the frozen cycles already completed; this one is the next.
            if (freeze && wait_q == WW'(MEM_TIMEOUT - 1)) timeout_q <= 1'b1;
        end
    end

    sat_counter #(.W(WW)) u_wait_cnt (
        .clk(clk), .reset(reset), .inc(freeze), .clr(~freeze), .q(wait_q)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(stall_inc), .clr(1'b0), .q(bus.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .inc(flush_inc), .clr(1'b0), .q(bus.flush_count)
    );

    assign bus.halted      = (state_q == ST_HALTED);
    assign bus.mem_timeout = timeout_q;
endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_controller_if #(.CNT_W(16)) bus ();

    hazard_controller #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(64), .CNT_W(16)) dut (
        .clk(clk), .reset(rst_n), .bus(bus.slave)
    );

    // Small-width saturating counter checked on its own.
    logic       sc_inc = 1'b0, sc_clr = 1'b0;
    logic [2:0] sc_q;
    sat_counter #(.W(3)) u_sc (.clk(clk), .reset(rst_n), .inc(sc_inc), .clr(sc_clr), .q(sc_q));

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
    logic [6:0] outs;
    assign outs = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                   bus.if_id_flush, bus.id_ex_flush};

    localparam logic [6:0] P_IDLE  = 7'b1111100;
    localparam logic [6:0] P_STALL = 7'b0011101;
    localparam logic [6:0] P_FLUSH = 7'b1111111;
    localparam logic [6:0] P_FRZ   = 7'b0000000;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] rs1, rs2;
        logic       u1, u2, halt;
        logic [3:0] rd;
        logic       mr, rw, br, req, ack;
        logic [6:0] exp;
        logic [1:0] dstall, dflush;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        bus.id_rs1 = v.rs1;  bus.id_rs2 = v.rs2;
        bus.id_use_rs1 = v.u1; bus.id_use_rs2 = v.u2; bus.id_halt = v.halt;
        bus.ex_rd = v.rd; bus.ex_mem_read = v.mr; bus.ex_reg_write = v.rw;
        bus.ex_branch_taken = v.br; bus.mem_req = v.req; bus.mem_ack = v.ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(vt[0]);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Load-use on R1 (LDR R1 in EX, ADD reading R1 in ID)
    task automatic set_load_use();
        bus.id_rs1 = 4'd1; bus.id_use_rs1 = 1'b1; bus.ex_rd = 4'd1;
        bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          rs1   rs2     u1 u2 hlt rd     mr rw br rq ak exp      ds df
        vt[0]  = '{4'd0, 4'd0,    0, 0, 0, 4'd0,   0, 0, 0, 0, 0, P_IDLE,  0, 0};
        vt[1]  = '{4'd1, 4'd0,    1, 0, 0, 4'd1,   1, 1, 0, 0, 0, P_STALL, 1, 0};
        vt[2]  = '{4'd5, REG_SP,  0, 1, 0, REG_SP, 1, 1, 0, 0, 0, P_STALL, 1, 0};
        vt[3]  = '{4'd1, 4'd0,    0, 0, 0, 4'd1,   1, 1, 0, 0, 0, P_IDLE,  0, 0};
        vt[4]  = '{4'd1, 4'd0,    1, 0, 0, 4'd1,   0, 1, 0, 0, 0, P_IDLE,  0, 0};
        vt[5]  = '{4'd1, 4'd0,    1, 0, 0, 4'd1,   1, 0, 0, 0, 0, P_IDLE,  0, 0};
        vt[6]  = '{4'd2, 4'd3,    1, 1, 0, REG_LR, 1, 1, 0, 0, 0, P_IDLE,  0, 0};
        vt[7]  = '{4'd0, 4'd0,    0, 0, 0, 4'd0,   0, 0, 1, 0, 0, P_FLUSH, 0, 1};
        vt[8]  = '{4'd1, 4'd0,    1, 0, 0, 4'd1,   1, 1, 1, 0, 0, P_FLUSH, 0, 1};
        vt[9]  = '{4'd1, 4'd0,    1, 0, 0, 4'd1,   1, 1, 1, 1, 0, P_FRZ,   0, 0};
        vt[10] = '{4'd1, 4'd0,    1, 0, 0, 4'd1,   1, 1, 0, 1, 1, P_STALL, 1, 0};
        vt[11] = '{4'd0, 4'd0,    0, 0, 1, 4'd0,   0, 0, 0, 0, 0, P_STALL, 0, 0};
        vt[12] = '{4'd1, 4'd0,    1, 0, 1, 4'd1,   1, 1, 0, 0, 0, P_STALL, 1, 0};
        vt[13] = '{4'd0, 4'd0,    0, 0, 1, 4'd0,   0, 0, 1, 0, 0, P_FLUSH, 0, 1};
        vt[14] = '{4'd0, 4'd0,    0, 0, 0, 4'd0,   0, 0, 0, 0, 1, P_IDLE,  0, 0};

        // Reset state
        set_in(vt[0]);
        #2 chk("rst_low_outs", outs, P_IDLE);
        tick(); tick();
        rst_n = 1'b1;
        #2;
        chk("rst_outs", outs, P_IDLE);
        chk("rst_halted", bus.halted, 0);
        chk("rst_timeout", bus.mem_timeout, 0);
        chk("rst_stall_cnt", bus.stall_count, 0);
        chk("rst_flush_cnt", bus.flush_count, 0);

        // Single-cycle vectors from a fresh RUN state
        for (int i = 0; i < 15; i++) begin
            do_reset();
            set_in(vt[i]);
            #2 chk($sformatf("vec%0d_outs", i), outs, vt[i].exp);
            tick();
            chk($sformatf("vec%0d_stall", i), bus.stall_count, vt[i].dstall);
            chk($sformatf("vec%0d_flush", i), bus.flush_count, vt[i].dflush);
        end

        // Memory freeze of 5 cycles with a branch and load-use waiting in EX/ID
        do_reset();
        set_load_use();
        bus.ex_branch_taken = 1'b1;
        bus.mem_req = 1'b1; bus.mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2 chk($sformatf("frz%0d_outs", i), outs, P_FRZ);
            tick();
        end
        chk("frz_stall_hold", bus.stall_count, 0);
        chk("frz_flush_hold", bus.flush_count, 0);
        bus.mem_ack = 1'b1;
        #2 chk("frz_resume_outs", outs, P_FLUSH);
        tick();
        set_in(vt[0]);
        chk("frz_resume_flush", bus.flush_count, 1);
        chk("frz_resume_stall", bus.stall_count, 0);
        #2 chk("frz_after_outs", outs, P_IDLE);

        // Halt drain with a freeze in the middle of DRAIN
        do_reset();
        bus.id_halt = 1'b1;
        #2 chk("halt_accept_outs", outs, P_STALL);
        tick();
        bus.id_halt = 1'b0;
        #2 chk("drain1_outs", outs, P_STALL);
        chk("drain1_halted", bus.halted, 0);
        tick();
        bus.mem_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2 chk($sformatf("drain_frz%0d_outs", i), outs, P_FRZ);
            tick();
        end
        bus.mem_req = 1'b0;
        #2 chk("drain2_outs", outs, P_STALL);
        chk("drain2_halted", bus.halted, 0);
        tick();
        #2 chk("drain3_outs", outs, P_STALL);
        chk("drain3_halted", bus.halted, 0);
        tick();
        #2 chk("halted_flag", bus.halted, 1);
        chk("halted_outs", outs, P_FRZ);
        set_load_use();
        bus.ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("halted_hold%0d_flag", i), bus.halted, 1);
            chk($sformatf("halted_hold%0d_outs", i), outs, P_FRZ);
        end
        chk("halted_flush_cnt", bus.flush_count, 0);
        chk("halted_stall_cnt", bus.stall_count, 0);
        rst_n = 1'b0;
        #1 chk("halted_rst_low_outs", outs, P_IDLE);
        tick();
        rst_n = 1'b1;
        set_in(vt[0]);
        #1 chk("halted_rst_flag", bus.halted, 0);
        chk("halted_rst_outs", outs, P_IDLE);

        // Branch taken during DRAIN cancels the halt
        do_reset();
        bus.id_halt = 1'b1;
        tick();
        bus.id_halt = 1'b0;
        bus.ex_branch_taken = 1'b1;
        #2 chk("cancel_outs", outs, P_FLUSH);
        tick();
        bus.ex_branch_taken = 1'b0;
        chk("cancel_flush_cnt", bus.flush_count, 1);
        for (int i = 0; i < 5; i++) begin
            #2 chk($sformatf("cancel_run%0d_outs", i), outs, P_IDLE);
            chk($sformatf("cancel_run%0d_halted", i), bus.halted, 0);
            tick();
        end

        // Memory timeout: sets after 64 consecutive wait cycles, sticky
        do_reset();
        bus.mem_req = 1'b1; bus.mem_ack = 1'b0;
        for (int i = 0; i < 63; i++) tick();
        chk("timeout_at63", bus.mem_timeout, 0);
        tick();
        chk("timeout_at64", bus.mem_timeout, 1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_req = 1'b0; bus.mem_ack = 1'b0;
        tick();
        chk("timeout_sticky", bus.mem_timeout, 1);
        do_reset();
        chk("timeout_rst", bus.mem_timeout, 0);

        // Reset asserted in the middle of DRAIN
        do_reset();
        bus.id_halt = 1'b1;
        tick();
        bus.id_halt = 1'b0;
        rst_n = 1'b0;
        #2 chk("middrain_rst_low_outs", outs, P_IDLE);
        tick();
        rst_n = 1'b1;
        #2 chk("middrain_rst_outs", outs, P_IDLE);
        chk("middrain_rst_halted", bus.halted, 0);
        tick();
        tick();
        chk("middrain_rst_stays_run", bus.halted, 0);

        // Saturation on a 3-bit counter
        do_reset();
        sc_inc = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("sat_hold_max", sc_q, 7);
        sc_clr = 1'b1;
        tick();
        sc_clr = 1'b0; sc_inc = 1'b0;
        chk("sat_clr", sc_q, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
